// File: rtl/rom_seq_pkg.sv
// ---------------------------------------------------------------------------
// rom_seq_pkg
// Shared definitions for the ROM sequencer slice: default address/data
// widths and the sequencer FSM state encoding.
// ---------------------------------------------------------------------------
package rom_seq_pkg;

    // Default ROM geometry: 8 words of 8 bits.
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned DATA_W_DEF = 8;

    // Sequencer states. IDLE waits for start, DRIVE/CAPT perform the ROM
    // read, OUT presents the word to the consumer, FIN signals completion.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        CAPT  = 3'd2,
        OUT   = 3'd3,
        FIN   = 3'd4
    } seq_state_e;

    // True when the state is one in which a scan is in progress.
    function automatic logic is_scan_state(input seq_state_e s);
        logic r;
        case (s)
            DRIVE, CAPT, OUT, FIN: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rom_sequencer_if.sv
// ---------------------------------------------------------------------------
// rom_sequencer_if
// Bundles the ROM read bus and the output word stream of the ROM sequencer.
//   rom_address : ADDR_W  address driven to the ROM
//   rom_sel     : 1       ROM enable
//   rom_data    : DATA_W  combinational ROM read data
//   out_data    : DATA_W  captured word
//   out_addr    : ADDR_W  address of out_data
//   out_valid   : 1       out_data/out_addr valid
//   out_ready   : 1       consumer accepts the word
// Modports:
//   master : sequencer side (drives the ROM bus and the output stream)
//   slave  : ROM + consumer side
// ---------------------------------------------------------------------------
interface rom_sequencer_if
    import rom_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] rom_address;
    logic              rom_sel;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output rom_address,
        output rom_sel,
        input  rom_data,
        output out_data,
        output out_addr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rom_address,
        input  rom_sel,
        output rom_data,
        input  out_data,
        input  out_addr,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/rom_sequencer_addr_counter.sv
// ---------------------------------------------------------------------------
// addr_counter
// ADDR_W-wide address counter for the ROM sequencer. Wraps modulo 2^ADDR_W.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset (count -> 0)
//   load_zero : load the counter with 0 (priority over inc_en)
//   inc_en    : increment by one
//   count     : current counter value
// ---------------------------------------------------------------------------
module addr_counter
    import rom_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_zero,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] count
);

    logic [ADDR_W-1:0] count_r;

    // Counter register: reset, load-zero, increment with natural wrap, hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {ADDR_W{1'b0}};
        end else if (load_zero) begin
            count_r <= {ADDR_W{1'b0}};
        end else if (inc_en) begin
            count_r <= count_r + ADDR_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/rom_sequencer.sv
// ---------------------------------------------------------------------------
// rom_sequencer
// Scans a combinational ROM from address 0 to 2^ADDR_W-1 after a start
// request. Each word takes DRIVE (address out), CAPT (data registered) and
// OUT (word offered until out_ready) cycles; done pulses for one cycle in FIN.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, aborts any scan without done
//   start : one-cycle scan request, ignored while busy
//   sif   : rom_sequencer_if.master (ROM bus + output word stream)
//   busy  : scan in progress (DRIVE, CAPT, OUT, FIN)
//   done  : one-cycle pulse when a scan completes
// Configuration:
//   ROM_SEQUENCER_LOOP_EN : when defined, FIN restarts the scan at address 0
//                           instead of returning to IDLE (continuous scanning).
// ---------------------------------------------------------------------------
module rom_sequencer
    import rom_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    rom_sequencer_if.master        sif,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    seq_state_e        state_r;
    logic [ADDR_W-1:0] count_s;
    logic              load_zero_s;
    logic              inc_en_s;
    logic              last_s;

    logic              rom_sel_r;
    logic [DATA_W-1:0] out_data_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;

    addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk       (clk),
        .reset     (reset),
        .load_zero (load_zero_s),
        .inc_en    (inc_en_s),
        .count     (count_s)
    );

    // Counter control decoded from the current state and handshake inputs.
    always_comb begin
        load_zero_s = 1'b0;
        inc_en_s    = 1'b0;
        last_s      = (count_s == LAST_ADDR);
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_zero_s = 1'b1;
                end else begin
                    load_zero_s = 1'b0;
                end
            end
            OUT: begin
                // The counter only moves when the word is accepted and more
                // words remain; the final address stays put until FIN.
                if (sif.out_ready && !last_s) begin
                    inc_en_s = 1'b1;
                end else begin
                    inc_en_s = 1'b0;
                end
            end
            FIN: begin
`ifdef ROM_SEQUENCER_LOOP_EN
                load_zero_s = 1'b1;
`else
                load_zero_s = 1'b0;
`endif
            end
            default: begin
                load_zero_s = 1'b0;
                inc_en_s    = 1'b0;
            end
        endcase
    end

    // Sequencer FSM; all outputs are registered and set for the state being
    // entered so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            rom_sel_r   <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_addr_r  <= {ADDR_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    if (start) begin
                        state_r   <= DRIVE;
                        rom_sel_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        rom_sel_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                DRIVE: begin
                    // Address has been on the bus for one cycle; hold it for
                    // the capture cycle so the ROM output is settled.
                    state_r   <= CAPT;
                    rom_sel_r <= 1'b1;
                    busy_r    <= 1'b1;
                end
                CAPT: begin
                    state_r     <= OUT;
                    out_data_r  <= sif.rom_data;
                    out_addr_r  <= count_s;
                    out_valid_r <= 1'b1;
                    rom_sel_r   <= 1'b0;
                    busy_r      <= 1'b1;
                end
                OUT: begin
                    if (sif.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (!last_s) begin
                            state_r   <= DRIVE;
                            rom_sel_r <= 1'b1;
                        end else begin
                            state_r   <= FIN;
                            rom_sel_r <= 1'b0;
                            done_r    <= 1'b1;
                        end
                    end else begin
                        state_r     <= OUT;
                        out_valid_r <= 1'b1;
                        rom_sel_r   <= 1'b0;
                    end
                end
                FIN: begin
                    done_r <= 1'b0;
`ifdef ROM_SEQUENCER_LOOP_EN
                    state_r   <= DRIVE;
                    rom_sel_r <= 1'b1;
                    busy_r    <= 1'b1;
`else
                    state_r   <= IDLE;
                    rom_sel_r <= 1'b0;
                    busy_r    <= 1'b0;
`endif
                end
                default: begin
                    state_r     <= IDLE;
                    rom_sel_r   <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    // The counter is itself a register, so it drives the ROM address directly.
    assign sif.rom_address = count_s;
    assign sif.rom_sel     = rom_sel_r;
    assign sif.out_data    = out_data_r;
    assign sif.out_addr    = out_addr_r;
    assign sif.out_valid   = out_valid_r;
    assign busy            = busy_r;
    assign done            = done_r;

endmodule

// File: doc/rom_sequencer.md
ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
- REQ-001 The parameter list SHALL be: ADDR_W, 3, ROM address width.
- REQ-002 The parameter list SHALL include: DATA_W, 8, ROM data width.
- REQ-003 The ports SHALL include: clk  input  1  single clock, rising edge.
- REQ-004 The ports SHALL include: reset  input  1  synchronous, active-high reset.
- REQ-005 The ports SHALL include: start  input  1  one-cycle request to begin a scan.
- REQ-006 The ports SHALL include: rom_address  output  ADDR_W  address driven to the ROM.
- REQ-007 The ports SHALL include: rom_sel  output  1  ROM enable.
- REQ-008 The ports SHALL include: rom_data  input  DATA_W  combinational ROM read data.
- REQ-009 The ports SHALL include: out_data  output  DATA_W  captured word.
- REQ-010 The ports SHALL include: out_addr  output  ADDR_W  address of out_data.
- REQ-011 The ports SHALL include: out_valid  output  1  out_data/out_addr valid.
- REQ-012 The ports SHALL include: out_ready  input  1  consumer accepts the word.
- REQ-013 The ports SHALL include: busy  output  1  scan in progress.
- REQ-014 The ports SHALL include: done  output  1  one-cycle pulse when a scan completes.

Function
- REQ-015 The block SHALL implement the FSM states IDLE, DRIVE, CAPT, OUT and FIN.
- REQ-016 IDLE: rom_sel=0, busy=0; start=1 loads addr counter with 0 and moves to DRIVE.
- REQ-017 DRIVE: rom_sel=1, rom_address=counter; next cycle moves to CAPT.
- REQ-018 CAPT: rom_sel=1, rom_address held; on the clock edge the block registers rom_data into out_data and counter into out_addr, then moves to OUT.
- REQ-019 OUT: out_valid=1, out_data/out_addr stable, rom_sel=0; stays in OUT while out_ready=0.
- REQ-020 OUT with out_ready=1 SHALL leave OUT: if counter≠2^ADDR_W−1, increment counter and go to DRIVE; else go to FIN.
- REQ-021 FIN: done=1 for exactly one cycle, then go to IDLE.
- REQ-022 busy SHALL be 1 in DRIVE, CAPT, OUT and FIN.
- REQ-023 Latency: first out_valid SHALL be asserted 3 cycles after the start edge; with out_ready held at 1, one word SHALL be produced every 3 cycles.
- REQ-024 start SHALL be ignored when busy=1.
- REQ-025 The counter SHALL wrap modulo 2^ADDR_W; out_addr SHALL use the same width, with no overflow flag.
- REQ-026 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
- REQ-027 On reset=1 at a clock edge, the state SHALL become IDLE and the counter 0.
- REQ-028 On reset, the outputs SHALL become rom_address=0, rom_sel=0, out_data=0, out_addr=0, out_valid=0, busy=0 and done=0.
- REQ-029 Reset SHALL abort a scan in any state; no done pulse SHALL be emitted for an aborted scan.
- REQ-030 start sampled in the same cycle as reset SHALL be ignored.

Configuration
- REQ-031 With macro ROM_SEQUENCER_LOOP_EN defined: in FIN (done pulse still issued) the block SHALL go to DRIVE with counter=0, scanning continuously until reset.
- REQ-032 Without ROM_SEQUENCER_LOOP_EN: the block SHALL perform a single scan, with FIN going to IDLE.

Structure
- REQ-033 A package rom_seq_pkg SHALL hold the FSM state enum typedef and the default ADDR_W/DATA_W constants.
- REQ-034 The address counter SHALL be a sub-module addr_counter (load-zero, increment enable, ADDR_W wide, synchronous reset) instantiated once.

Verification
- REQ-035 Scenario 1: stub ROM data=address*0x11 and out_ready=1, pulse start -> 8 words 0x00,0x11,…,0x77 with out_addr 0..7, then a single done pulse and busy=0.
- REQ-036 Scenario 2: hold out_ready=0 for 5 cycles at word 3 -> out_valid, out_data=0x33 and out_addr=3 stable throughout, rom_sel=0, no counter advance.
- REQ-037 Scenario 3: start pulse at word 4 of a scan -> no restart; sequence continues 5,6,7.
- REQ-038 Scenario 4: reset asserted in CAPT of word 2 -> all outputs 0 next cycle, no done pulse; a later start rescans from address 0.
- REQ-039 Scenario 5: check timing -> rom_address is stable for both DRIVE and CAPT cycles, and out_valid rises exactly 3 cycles after start.
- REQ-040 Scenario 6 (LOOP_EN build): done pulses after word 7, and the next word has out_addr=0 without a new start.
